// File: rtl/config_bus_pkg.sv
// Shared types and constants for the configuration bus loader.
`timescale 1ns/1ps
package config_bus_pkg;

  // Loader control states.
  typedef enum logic [2:0] {
    StIdle,
    StCntLo,
    StCntHi,
    StRec,
    StWrite,
    StDone
  } state_e;

  // Block ids carried in config_addr[31:16]; id 0 is never decoded by a tile.
  localparam logic [15:0] CONFIG_RESERVED      = 16'd0;
  localparam logic [15:0] CONFIG_compute_block = 16'd4;
  localparam logic [15:0] CONFIG_cb1           = 16'd5;
  localparam logic [15:0] CONFIG_cb0           = 16'd6;
  localparam logic [15:0] CONFIG_sb            = 16'd7;

  // One record is a 32-bit address followed by 32-bit data, little-endian.
  localparam int unsigned RECORD_BYTES = 8;
  localparam int unsigned RECORD_W     = 8 * RECORD_BYTES;

endpackage

// File: rtl/config_loader_if.sv
// Byte-stream input and configuration-bus output of the loader.
`timescale 1ns/1ps
interface config_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;

  // The loader side: consumes the stream, drives the bus.
  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output config_addr,
    output config_data
  );

  // The environment side: supplies the stream, observes the bus.
  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  config_addr,
    input  config_data
  );
endinterface

// File: rtl/byte_shift_assembler.sv
// Collects little-endian stream bytes into one (addr, data) record.
`timescale 1ns/1ps
module byte_shift_assembler
  import config_bus_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                shift_i,
  input  logic [7:0]          byte_i,
  output logic [RECORD_W-1:0] record_o,
  output logic                last_o
);

  localparam int unsigned IdxW = $clog2(RECORD_BYTES);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(RECORD_BYTES - 1);

  logic [RECORD_W-1:0] record_q;
  logic [IdxW-1:0]     idx_q;

  // record_o already includes the byte being shifted in, so the loader can latch the
  // complete record on the same edge that accepts the final byte.
  assign record_o = {byte_i, record_q[RECORD_W-1:8]};
  assign last_o   = shift_i && (idx_q == IdxLast);

  // Shift register and byte index; index wraps to 0 after the last byte.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      record_q <= '0;
      idx_q    <= '0;
    end else if (shift_i) begin
      record_q <= record_o;
      idx_q    <= idx_q + IdxW'(1);
    end
  end

endmodule

// File: rtl/config_loader.sv
// Configuration-bus master: reads a record count then (addr, data) records from a byte
// stream and issues one single-cycle bus write per record.
`timescale 1ns/1ps
module config_loader
  import config_bus_pkg::*;
#(
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000,
  parameter logic [15:0] MAX_RECORDS = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  config_loader_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [15:0]            records_written
);

  state_e        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [7:0]    cnt_lo_q, cnt_lo_d;
  logic [15:0]   rw_q, rw_d;
  logic          error_q, error_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;

  logic                xfer;
  logic                asm_clear;
  logic                asm_shift;
  logic                asm_last;
  logic [RECORD_W-1:0] asm_record;
  logic [15:0]         cnt_full;

  assign xfer      = bus.in_valid && in_ready_q;
  assign asm_shift = xfer && (state_q == StRec);
  assign cnt_full  = {bus.in_data, cnt_lo_q};

  byte_shift_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (asm_clear),
    .shift_i  (asm_shift),
    .byte_i   (bus.in_data),
    .record_o (asm_record),
    .last_o   (asm_last)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cnt_lo_d  = cnt_lo_q;
    rw_d      = rw_q;
    error_d   = error_q;
    addr_d    = IDLE_ADDR;
    data_d    = data_q;
    asm_clear = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StCntLo;
          error_d   = 1'b0;
          rw_d      = '0;
          asm_clear = 1'b1;
        end
      end
      StCntLo: begin
        if (xfer) begin
          cnt_lo_d = bus.in_data;
          state_d  = StCntHi;
        end
      end
      StCntHi: begin
        if (xfer) begin
          if (cnt_full > MAX_RECORDS) begin
            count_d = MAX_RECORDS;
            error_d = 1'b1;
          end else begin
            count_d = cnt_full;
          end
          state_d = (count_d == '0) ? StDone : StRec;
        end
      end
      StRec: begin
        if (asm_last) begin
          state_d = StWrite;
          addr_d  = asm_record[31:0];
          data_d  = asm_record[63:32];
        end
      end
      StWrite: begin
        rw_d    = rw_q + 16'd1;
        count_d = count_q - 16'd1;
        state_d = (count_q == 16'd1) ? StDone : StRec;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    in_ready_d = (state_d == StCntLo) || (state_d == StCntHi) || (state_d == StRec);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  // State and output registers; reset also drops any partial record.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      cnt_lo_q   <= '0;
      rw_q       <= '0;
      error_q    <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= IDLE_ADDR;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cnt_lo_q   <= cnt_lo_d;
      rw_q       <= rw_d;
      error_q    <= error_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.config_addr = addr_q;
  assign bus.config_data = data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign records_written = rw_q;

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: expected bus writes are queued by the stimulus and
// consumed by per-instance monitors whenever a write appears on the bus.
`timescale 1ns/1ps
module tb_config_loader;
  import config_bus_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       s_start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       sel     = 1'b0;  // 0: default instance, 1: MAX_RECORDS=2 instance

  int     n_cmp  = 0;
  int     n_fail = 0;
  longint cyc    = 0;
  always @(posedge clk) cyc++;

  config_loader_if if1 ();
  config_loader_if if2 ();

  logic        start1, start2, busy1, busy2, done1, done2, err1, err2;
  logic [15:0] rw1, rw2;

  assign if1.in_data  = s_data;
  assign if2.in_data  = s_data;
  assign if1.in_valid = s_valid && !sel;
  assign if2.in_valid = s_valid && sel;
  assign start1       = s_start && !sel;
  assign start2       = s_start && sel;

  config_loader dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start1),
    .bus             (if1),
    .busy            (busy1),
    .done            (done1),
    .error           (err1),
    .records_written (rw1)
  );

  config_loader #(.MAX_RECORDS(16'd2)) dut2 (
    .clk             (clk),
    .reset           (reset),
    .start           (start2),
    .bus             (if2),
    .busy            (busy2),
    .done            (done2),
    .error           (err2),
    .records_written (rw2)
  );

  logic        cur_ready, cur_busy, cur_done, cur_err;
  logic [15:0] cur_rw;
  logic [31:0] cur_addr;
  assign cur_ready = sel ? if2.in_ready    : if1.in_ready;
  assign cur_busy  = sel ? busy2           : busy1;
  assign cur_done  = sel ? done2           : done1;
  assign cur_err   = sel ? err2            : err1;
  assign cur_rw    = sel ? rw2             : rw1;
  assign cur_addr  = sel ? if2.config_addr : if1.config_addr;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Expected writes as {addr, data}.
  logic [63:0] q1[$];
  logic [63:0] q2[$];
  bit          gap_chk = 1'b0;
  longint      last_w1 = -1;

  // Monitor for the default instance.
  always @(negedge clk) begin
    if (!reset && if1.config_addr != 32'h0) begin
      chk("ready_in_write1", 64'(if1.in_ready), 64'd0);
      if (q1.size() == 0) begin
        chk("unexpected_write1", 64'(if1.config_addr), 64'd0);
      end else begin
        logic [63:0] e;
        e = q1.pop_front();
        chk("wr_addr1", 64'(if1.config_addr), 64'(e[63:32]));
        chk("wr_data1", 64'(if1.config_data), 64'(e[31:0]));
      end
      if (gap_chk && last_w1 >= 0) chk("wr_gap1", 64'(cyc - last_w1), 64'd9);
      last_w1 = cyc;
    end
  end

  // Monitor for the clamped instance.
  always @(negedge clk) begin
    if (!reset && if2.config_addr != 32'h0) begin
      chk("ready_in_write2", 64'(if2.in_ready), 64'd0);
      if (q2.size() == 0) begin
        chk("unexpected_write2", 64'(if2.config_addr), 64'd0);
      end else begin
        logic [63:0] e;
        e = q2.pop_front();
        chk("wr_addr2", 64'(if2.config_addr), 64'(e[63:32]));
        chk("wr_data2", 64'(if2.config_data), 64'(e[31:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and hold it until an edge where in_ready was high.
  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic rdy;
    n = 0;
    s_data  = b;
    s_valid = 1'b1;
    do begin
      rdy = cur_ready;
      tick();
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk("send_byte_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
  endtask

  task automatic send_rec(input logic [31:0] addr, input logic [31:0] data);
    logic [63:0] r;
    r = {data, addr};
    if (sel) q2.push_back({addr, data});
    else     q1.push_back({addr, data});
    for (int i = 0; i < 8; i++) send_byte(r[8*i +: 8]);
  endtask

  task automatic pulse_start();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!cur_done && n < 300) begin
      tick();
      n++;
    end
    chk(name, 64'(cur_done), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;

    // Reset values.
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_ready",   64'(if1.in_ready),    64'd0);
    chk("rst_addr",    64'(if1.config_addr), 64'd0);
    chk("rst_data",    64'(if1.config_data), 64'd0);
    chk("rst_busy",    64'(busy1),           64'd0);
    chk("rst_done",    64'(done1),           64'd0);
    chk("rst_err",     64'(err1),            64'd0);
    chk("rst_rw",      64'(rw1),             64'd0);

    // Single record from explicit bytes.
    sel = 1'b0;
    pulse_start();
    chk("start_busy", 64'(cur_busy), 64'd1);
    send_byte(8'h01); send_byte(8'h00);
    q1.push_back({32'h0004_0003, 32'h0000_0001});
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("single_bus_now", 64'(cur_addr), 64'h0004_0003);
    wait_done("single_done");
    chk("single_rw", 64'(cur_rw), 64'd1);
    tick();
    chk("single_done_clr", 64'(cur_done), 64'd0);
    chk("single_busy_clr", 64'(cur_busy), 64'd0);
    chk("single_addr_idle", 64'(cur_addr), 64'd0);

    // Zero count.
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    chk("zero_done", 64'(cur_done), 64'd1);
    chk("zero_rw", 64'(cur_rw), 64'd0);
    tick();
    chk("zero_busy_clr", 64'(cur_busy), 64'd0);

    // Back-to-back records with the stream never stalling.
    gap_chk = 1'b1;
    last_w1 = -1;
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    send_rec(32'h0007_0001, 32'h0000_00AA);
    send_rec(32'h0006_0001, 32'h0000_0005);
    send_rec(32'h0005_0002, 32'h0000_0003);
    wait_done("b2b_done");
    chk("b2b_rw", 64'(cur_rw), 64'd3);
    tick();
    gap_chk = 1'b0;

    // Stall after byte 5 of the record.
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    q1.push_back({32'h0006_0003, 32'hDEAD_BEEF});
    r = {32'hDEAD_BEEF, 32'h0006_0003};
    for (int i = 0; i < 6; i++) send_byte(r[8*i +: 8]);
    repeat (20) tick();
    chk("stall_rw", 64'(cur_rw), 64'd0);
    chk("stall_busy", 64'(cur_busy), 64'd1);
    chk("stall_ready", 64'(cur_ready), 64'd1);
    chk("stall_pending", 64'(q1.size()), 64'd1);
    send_byte(r[55:48]); send_byte(r[63:56]);
    wait_done("stall_done");
    chk("stall_rw_after", 64'(cur_rw), 64'd1);
    tick();

    // Reset in the middle of the second record.
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_rec(32'h0005_0002, 32'h0000_0011);
    r = {32'h0000_0099, 32'h0007_0009};
    for (int i = 0; i < 4; i++) send_byte(r[8*i +: 8]);
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", 64'(cur_busy), 64'd0);
    chk("mid_rst_addr", 64'(cur_addr), 64'd0);
    chk("mid_rst_ready", 64'(cur_ready), 64'd0);
    chk("mid_rst_rw", 64'(cur_rw), 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_rec(32'h0004_0001, 32'h0000_0022);
    wait_done("after_rst_done");
    chk("after_rst_rw", 64'(cur_rw), 64'd1);
    tick();

    // Clamp on the MAX_RECORDS=2 instance, with a start pulse while busy.
    sel = 1'b1;
    pulse_start();
    send_byte(8'h05); send_byte(8'h00);
    chk("clamp_err", 64'(cur_err), 64'd1);
    q2.push_back({32'h0007_0003, 32'h0000_0077});
    r = {32'h0000_0077, 32'h0007_0003};
    for (int i = 0; i < 3; i++) send_byte(r[8*i +: 8]);
    pulse_start();
    for (int i = 3; i < 8; i++) send_byte(r[8*i +: 8]);
    send_rec(32'h0004_0004, 32'h0000_0088);
    wait_done("clamp_done");
    chk("clamp_rw", 64'(cur_rw), 64'd2);
    chk("clamp_err_sticky", 64'(cur_err), 64'd1);
    tick();
    chk("clamp_idle_ready", 64'(cur_ready), 64'd0);
    chk("clamp_busy_clr", 64'(cur_busy), 64'd0);
    pulse_start();
    chk("clamp_err_cleared", 64'(cur_err), 64'd0);
    send_byte(8'h00); send_byte(8'h00);
    wait_done("clamp_zero_done");
    tick();

    chk("sb1_empty", 64'(q1.size()), 64'd0);
    chk("sb2_empty", 64'(q2.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
